// File: rtl/square_spawner.sv
`default_nettype none
// ============================================================================
// Module   : square_spawner
// Purpose  : Seeds 16 bouncing-square slots from an LFSR, then latches the
//            per-frame update from random_square and drives the active mask.
// Revision : 1.0
// ============================================================================
module square_spawner #(
    parameter int          NUM_SQUARES = 16,
    parameter int          X_MAX       = 639,
    parameter int          Y_MAX       = 479,
    parameter int          SQUARE_SIZE = 10,
    parameter int          SPEED       = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        refresh_tick,
    input  logic                        respawn,
    input  logic [4:0]                  num_square,
    input  logic [40*NUM_SQUARES-1:0]   position_next,
    output logic [40*NUM_SQUARES-1:0]   position,
    output logic [NUM_SQUARES-1:0]      active_mask,
    output logic                        ready
);

    localparam int               IDX_W    = $clog2(NUM_SQUARES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SQUARES - 1);
    localparam logic [9:0]       X_LIM    = 10'(X_MAX - SQUARE_SIZE);
    localparam logic [9:0]       Y_LIM    = 10'(Y_MAX - SQUARE_SIZE);
    localparam logic [9:0]       POS_D    = 10'(SPEED);
    localparam logic [9:0]       NEG_D    = 10'(-SPEED);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_next;
    logic [IDX_W-1:0]  idx;
    logic              tick_d1;
    logic [9:0]        raw_x;
    logic [9:0]        raw_y;
    logic [39:0]       new_slot;
    logic [NUM_SQUARES-1:0] mask_next;

    always_comb begin
        lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Clamping keeps squares on-screen for any geometry; it never bites at the
    // default 640x480 because the raw ranges stop at 512 and 383.
    always_comb begin
        raw_x    = 10'd1 + {1'b0, lfsr[8:0]};
        raw_y    = 10'd1 + {2'b00, lfsr[15:8]} + {3'b000, lfsr[15:9]};
        new_slot = {
            (lfsr[1] ? POS_D : NEG_D),
            (lfsr[0] ? POS_D : NEG_D),
            ((raw_y > Y_LIM) ? Y_LIM : raw_y),
            ((raw_x > X_LIM) ? X_LIM : raw_x)
        };
    end

    always_comb begin
        mask_next = '0;
        for (int i = 0; i < NUM_SQUARES; i++) begin
            mask_next[i] = (i < int'(num_square));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_INIT;
            lfsr        <= LFSR_SEED;
            idx         <= '0;
            tick_d1     <= 1'b0;
            position    <= '0;
            active_mask <= '0;
            ready       <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                ST_INIT: begin
                    // Ticks seen during INIT must not leak into the first RUN cycle.
                    tick_d1 <= 1'b0;
                    for (int i = 0; i < NUM_SQUARES; i++) begin
                        if (idx == IDX_W'(i)) begin
                            position[40*i +: 40] <= new_slot;
                        end
                    end
                    if (respawn) begin
                        idx <= '0;
                    end else if (idx == LAST_IDX) begin
                        idx         <= '0;
                        state       <= ST_RUN;
                        ready       <= 1'b1;
                        active_mask <= mask_next;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_RUN: begin
                    tick_d1 <= refresh_tick;
                    if (respawn) begin
                        state <= ST_INIT;
                        idx   <= '0;
                        ready <= 1'b0;
                    end else if (tick_d1) begin
                        position    <= position_next;
                        active_mask <= mask_next;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    idx   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_square_spawner.sv
`default_nettype none
// ============================================================================
// Module   : tb_square_spawner
// Purpose  : Randomised self-checking bench for square_spawner.
// Revision : 1.0
// ============================================================================
module tb_square_spawner;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [39:0] SLOT0_REF = {10'h3FE, 10'h002, 10'd259, 10'd226};

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         refresh_tick = 1'b0;
    logic         respawn = 1'b0;
    logic [4:0]   num_square = 5'd0;
    logic [639:0] position_next = '0;
    logic [639:0] position;
    logic [15:0]  active_mask;
    logic         ready;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0]  model_l = SEED;
    logic [639:0] exp_pos = '0;
    logic [15:0]  exp_mask = '0;
    logic [39:0]  first_run [16];

    square_spawner dut (
        .clk           (clk),
        .reset         (reset),
        .refresh_tick  (refresh_tick),
        .respawn       (respawn),
        .num_square    (num_square),
        .position_next (position_next),
        .position      (position),
        .active_mask   (active_mask),
        .ready         (ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR: free-running from the seed whenever reset is released.
    always @(posedge clk or negedge reset) begin
        if (!reset) model_l <= SEED;
        else        model_l <= lfsr_step(model_l);
    end

    function automatic logic [39:0] slot_of(input logic [15:0] l);
        int x, y;
        logic [9:0] xd, yd;
        x  = 1 + int'(l[8:0]);
        y  = 1 + int'(l[15:8]) + int'(l[15:9]);
        xd = l[0] ? 10'd2 : 10'h3FE;
        yd = l[1] ? 10'd2 : 10'h3FE;
        return {yd, xd, 10'(y), 10'(x)};
    endfunction

    function automatic logic [15:0] mask_for(input int n);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) m[i] = (i < n);
        return m;
    endfunction

    function automatic logic [639:0] rand_bus();
        logic [639:0] b;
        for (int i = 0; i < 20; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            refresh_tick  = 1'($urandom);
            respawn       = 1'($urandom);
            num_square    = 5'($urandom);
            position_next = rand_bus();
            @(posedge clk); #1;
            vectors++;
            if (position !== '0 || active_mask !== 16'h0 || ready !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold: got pos_nonzero=%0b mask=%h ready=%b required 0/0000/0",
                         (position !== '0), active_mask, ready);
            end
        end
        refresh_tick = 1'b0;
        respawn      = 1'b0;
        exp_pos      = '0;
        exp_mask     = '0;
    endtask

    // Releases reset and walks all 16 init edges; reset must be low on entry.
    task automatic run_init(input bit first);
        logic [39:0] s;
        @(negedge clk);
        num_square = 5'd5;
        respawn    = 1'b0;
        reset      = 1'b1;
        for (int k = 0; k < 16; k++) begin
            refresh_tick  = (k >= 14) ? 1'b1 : 1'($urandom);
            position_next = rand_bus();
            s = slot_of(model_l);
            exp_pos[40*k +: 40] = s;
            @(posedge clk); #1;
            vectors++;
            if (position !== exp_pos) begin
                miscompares++;
                $display("FAIL init_slot%0d: got %h required %h", k, position[40*k +: 40], s);
            end
            vectors++;
            if (ready !== (k == 15)) begin
                miscompares++;
                $display("FAIL init_ready_edge%0d: got %b required %b", k + 1, ready, (k == 15));
            end
            if (k == 0) begin
                vectors++;
                if (position[39:0] !== SLOT0_REF) begin
                    miscompares++;
                    $display("FAIL init_slot0_const: got %h required %h", position[39:0], SLOT0_REF);
                end
            end
            if (first) begin
                first_run[k] = s;
            end else begin
                vectors++;
                if (position[40*k +: 40] !== first_run[k]) begin
                    miscompares++;
                    $display("FAIL replay_slot%0d: got %h required %h", k, position[40*k +: 40], first_run[k]);
                end
            end
            @(negedge clk);
        end
        exp_mask = mask_for(5);
        vectors++;
        if (active_mask !== 16'h001F) begin
            miscompares++;
            $display("FAIL init_mask: got %h required 001f", active_mask);
        end
        // The tick sampled on the last INIT edge must not cause a capture.
        refresh_tick = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (position !== exp_pos) begin
            miscompares++;
            $display("FAIL pending_tick_discard: got %h required %h", position, exp_pos);
        end
    endtask

    task automatic test_init_values();
        run_init(1'b1);
    endtask

    task automatic test_mask();
        int n;
        for (int r = 0; r < 6; r++) begin
            n = (r == 0) ? 20 : (r == 1) ? 0 : (r == 2) ? 16 : $urandom_range(0, 31);
            @(negedge clk);
            num_square    = 5'(n);
            position_next = rand_bus();
            refresh_tick  = 1'b1;
            @(posedge clk); #1;
            vectors++;
            if (active_mask !== exp_mask) begin
                miscompares++;
                $display("FAIL mask_early_n%0d: got %h required %h", n, active_mask, exp_mask);
            end
            @(negedge clk);
            refresh_tick = 1'b0;
            @(posedge clk); #1;
            exp_mask = mask_for(n);
            exp_pos  = position_next;
            vectors++;
            if (active_mask !== exp_mask || position !== exp_pos) begin
                miscompares++;
                $display("FAIL mask_after_tick_n%0d: got %h required %h", n, active_mask, exp_mask);
            end
        end
    endtask

    task automatic test_capture();
        logic prev_tick;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            position_next = ~exp_pos ^ rand_bus();
            for (int c = 0; c < 3 + r; c++) begin
                @(posedge clk); #1;
                vectors++;
                if (position !== exp_pos) begin
                    miscompares++;
                    $display("FAIL capture_hold: got %h required %h", position, exp_pos);
                end
            end
            @(negedge clk);
            refresh_tick = 1'b1;
            @(posedge clk); #1;
            vectors++;
            if (position !== exp_pos) begin
                miscompares++;
                $display("FAIL capture_edge_n: got %h required %h", position, exp_pos);
            end
            @(negedge clk);
            refresh_tick = 1'b0;
            @(posedge clk); #1;
            exp_pos = position_next;
            vectors++;
            if (position !== exp_pos) begin
                miscompares++;
                $display("FAIL capture_edge_n1: got %h required %h", position, exp_pos);
            end
        end
        // Random back-to-back ticks with a changing bus and mask request.
        prev_tick = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            position_next = rand_bus();
            num_square    = 5'($urandom);
            refresh_tick  = 1'($urandom);
            @(posedge clk); #1;
            if (prev_tick) begin
                exp_pos  = position_next;
                exp_mask = mask_for(int'(num_square));
            end
            prev_tick = refresh_tick;
            vectors++;
            if (position !== exp_pos || active_mask !== exp_mask) begin
                miscompares++;
                $display("FAIL back_to_back_c%0d: got mask %h pos %h required mask %h pos %h",
                         c, active_mask, position, exp_mask, exp_pos);
            end
        end
        @(negedge clk);
        refresh_tick = 1'b0;
        @(posedge clk); #1;
        if (prev_tick) begin
            exp_pos  = position_next;
            exp_mask = mask_for(int'(num_square));
        end
    endtask

    task automatic test_respawn_conflict();
        logic [39:0] s;
        int n;
        @(negedge clk);
        refresh_tick  = 1'b1;
        position_next = ~exp_pos;
        @(posedge clk); #1;
        @(negedge clk);
        refresh_tick = 1'b0;
        respawn      = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (ready !== 1'b0 || position !== exp_pos || active_mask !== exp_mask) begin
            miscompares++;
            $display("FAIL respawn_conflict: got ready=%b mask=%h captured=%0b required ready=0 mask=%h captured=0",
                     ready, active_mask, (position !== exp_pos), exp_mask);
        end
        @(negedge clk);
        respawn    = 1'b0;
        n          = $urandom_range(1, 15);
        num_square = 5'(n);
        for (int k = 0; k < 16; k++) begin
            refresh_tick  = 1'($urandom);
            position_next = rand_bus();
            s = slot_of(model_l);
            exp_pos[40*k +: 40] = s;
            @(posedge clk); #1;
            if (k == 15) exp_mask = mask_for(n);
            vectors++;
            if (position !== exp_pos || ready !== (k == 15) || active_mask !== exp_mask) begin
                miscompares++;
                $display("FAIL respawn_slot%0d: got slot %h ready %b mask %h required slot %h ready %b mask %h",
                         k, position[40*k +: 40], ready, active_mask, s, (k == 15), exp_mask);
            end
            @(negedge clk);
        end
        refresh_tick = 1'b0;
    endtask

    task automatic test_reset_mid_init();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        num_square = 5'd5;
        reset      = 1'b1;
        exp_pos    = '0;
        for (int k = 0; k < 8; k++) begin
            refresh_tick = 1'($urandom);
            exp_pos[40*k +: 40] = slot_of(model_l);
            @(posedge clk); #1;
            vectors++;
            if (position !== exp_pos) begin
                miscompares++;
                $display("FAIL midinit_slot%0d: got %h required %h", k, position[40*k +: 40], exp_pos[40*k +: 40]);
            end
            @(negedge clk);
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (position !== '0 || active_mask !== 16'h0 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midinit_async_reset: got pos_nonzero=%0b mask=%h ready=%b required 0/0000/0",
                     (position !== '0), active_mask, ready);
        end
        refresh_tick = 1'b0;
        exp_pos      = '0;
        exp_mask     = '0;
        @(negedge clk);
        run_init(1'b0);
    endtask

    initial begin
        test_reset();
        test_init_values();
        test_mask();
        test_capture();
        test_respawn_conflict();
        test_reset_mid_init();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/square_spawner.md
# square_spawner

Owns the packed square-state register that feeds `random_square` and consumes its `position_next` output. After reset or a respawn request it fills the 16 square slots with pseudo-random positions and velocities, one slot per clock, from an internal LFSR. It then latches the updated state from `random_square` once per frame. It also produces the active-square mask that the downstream renderer uses.

## Interface
- `NUM_SQUARES`, 16 — slot count; bus width is 40·NUM_SQUARES (640)
- `X_MAX`, 639 — right border of the display area
- `Y_MAX`, 479 — bottom border of the display area
- `SQUARE_SIZE`, 10 — square side length in pixels
- `SPEED`, 2 — magnitude of the initial velocity
- `LFSR_SEED`, 16'hACE1 — LFSR reset value; must be nonzero

- `clk`  in  1  — single clock; everything is on the rising edge
- `reset`  in  1  — asynchronous, active-low reset (`reset`=0 resets the block)
- `refresh_tick`  in  1  — one-cycle frame pulse; the same signal drives `random_square`
- `respawn`  in  1  — one-cycle request to re-randomise all slots
- `num_square`  in  5  — requested active count; values above 16 are clamped to 16
- `position_next`  in  640  — updated state from `random_square`
- `position`  out  640  — current state; drives `random_square.position` and the renderer
- `active_mask`  out  16  — bit i=1 means slot i is drawn
- `ready`  out  1  — 1 while in RUN

## Operation
- Slot i occupies `position[40i+39:40i]` = {y_delta, x_delta, sq_y, sq_x}, each field 10 bits.
  - Deltas are 10-bit two's complement: +2 = 10'h002, −2 = 10'h3FE.
- LFSR is a 16-bit Galois type.
  - Next value = (l>>1) ^ (l[0] ? 16'hB400 : 0).
  - It advances on every clock in both states.
  - It is never reloaded except by `reset`.
- Reset state: `lfsr`=LFSR_SEED, `position`=0, `active_mask`=0, `ready`=0, state=INIT, `idx`=0.
- INIT: on each edge, slot `idx` is written from the current (pre-advance) LFSR value l, and `idx` increments.
  - sq_x = 1 + l[8:0], range 1..512.
  - sq_y = 1 + l[15:8] + l[15:9], range 1..383.
  - x_delta = l[0] ? +SPEED : −SPEED.
  - y_delta = l[1] ? +SPEED : −SPEED.
  - Every generated square lies fully inside X_MAX/Y_MAX.
- INIT → RUN: on the edge that writes slot 15.
  - Same edge: `ready`←1, `active_mask`←(1<<min(num_square,16))−1.
  - `num_square`=0 gives mask 0.
- RUN: `position`←`position_next` (all 640 bits) on the edge after `refresh_tick` was sampled high.
  - Internal `tick_d1` covers the one-cycle register latency of `random_square`.
  - `active_mask` is refreshed from `num_square` on the same edge.
  - `position` holds on all other edges.
- `respawn` in RUN: → INIT, `idx`←0, `ready`←0 on the next edge.
  - `active_mask` holds its value.
  - Slots not yet rewritten keep their old contents.
- `respawn` in INIT: `idx` restarts at 0; the LFSR keeps running.
- `refresh_tick` and `tick_d1` are ignored in INIT.
  - A `tick_d1` left pending when RUN is re-entered is discarded.
- Simultaneous `respawn` and `tick_d1` in RUN: `respawn` wins, and no capture happens.
- `reset` asserted at any time, including mid-INIT: immediate return to the reset state.

## Timing
- After `reset` is released, slot k is written on edge k+1 (k=0..15).
  - `ready`=1 after edge 16.
  - INIT always takes 16 cycles.
- Capture latency: `refresh_tick` high at edge n → `position` updated at edge n+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold `reset`=0 and toggle inputs → `position`=0, `active_mask`=0, `ready`=0 throughout.
- Init values: seed 16'hACE1, release `reset`.
  - Edge 1: slot 0 = {10'h3FE, 10'h002, 10'd259, 10'd226}.
  - Slots 1–15 match a reference-model LFSR.
  - `ready` rises exactly at edge 16.
- Mask:
  - `num_square`=5 at the INIT end → `active_mask`=16'h001F.
  - Change `num_square` to 20, pulse `refresh_tick` → 16'hFFFF one edge after the tick.
- Capture: in RUN, drive `position_next` to a pattern differing from `position`.
  - With no tick, `position` is unchanged.
  - Pulse the tick at edge n → `position` equals the pattern at edge n+1.
- Respawn/tick conflict: tick at edge n, `respawn` at edge n+1.
  - No capture happens, `ready`=0, and slot 0 is rewritten from the current LFSR.
  - Ticks are ignored for the next 16 edges; `ready`=1 at edge n+17.
- Reset mid-INIT: assert `reset` after slot 7 is written → immediate return to the reset state; the init sequence then replays identically to the Init values test.
